// File: rtl/r5p_tcb_mem_sub_pkg.sv
// ---------------------------------------------------------------------------
// r5p_tcb_mem_sub_pkg
//   Shared TCB-Lite types and helpers for the r5p subordinate memory.
//   - TCB_XLEN     : bus data/address width (32 only)
//   - TCB_DLY_MAX  : largest supported response delay
//   - tcb_req_t    : request payload (lck, ndn, wen, ren, siz, adr, byt, wdt)
//   - tcb_sts_t    : response status (err)
//   - tcb_rsp_t    : response payload (rdt, sts)
//   - tcb_ben()    : RISC-V byte-enable decode from siz and adr[1:0]
// ---------------------------------------------------------------------------
package r5p_tcb_mem_sub_pkg;

  localparam int TCB_XLEN    = 32;
  localparam int TCB_DLY_MAX = 4;

  typedef struct packed {
    logic                  lck;
    logic                  ndn;
    logic                  wen;
    logic                  ren;
    logic [1:0]            siz;
    logic [TCB_XLEN-1:0]   adr;
    logic [TCB_XLEN/8-1:0] byt;
    logic [TCB_XLEN-1:0]   wdt;
  } tcb_req_t;

  typedef struct packed {
    logic err;
  } tcb_sts_t;

  typedef struct packed {
    logic [TCB_XLEN-1:0] rdt;
    tcb_sts_t            sts;
  } tcb_rsp_t;

  // siz=3 is illegal and decodes like a full word; the half-word lane pair
  // is chosen by adr[1] alone, so adr[0] never shifts the lanes.
  function automatic logic [3:0] tcb_ben(input logic [1:0] siz, input logic [1:0] adr);
    logic [3:0] ben;
    case (siz)
      2'd0:    ben = 4'b0001 << adr;
      2'd1:    ben = adr[1] ? 4'b1100 : 4'b0011;
      default: ben = 4'b1111;
    endcase
    return ben;
  endfunction

endpackage

// File: rtl/r5p_tcb_mem_sub_if.sv
// ---------------------------------------------------------------------------
// r5p_tcb_mem_sub_if
//   TCB-Lite bus bundle between a manager (IFU/LSU) and a subordinate.
//   Handshake: a transfer happens in every cycle where vld & rdy are both 1.
//   The manager keeps req stable while vld=1 and rdy=0; the subordinate may
//   drive rdy independently of vld. The response for a read appears a fixed
//   number of cycles after the transfer and stays until the next response.
//   Modports: man (drives vld/req), sub (drives rdy/rsp).
// ---------------------------------------------------------------------------
interface r5p_tcb_mem_sub_if;
  import r5p_tcb_mem_sub_pkg::*;

  logic     vld;
  logic     rdy;
  tcb_req_t req;
  tcb_rsp_t rsp;

  modport man (output vld, output req, input rdy, input rsp);
  modport sub (input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/r5p_tcb_mem_sub_pipe.sv
// ---------------------------------------------------------------------------
// r5p_tcb_mem_sub_pipe
//   DLY-cycle response pipe: DLY-1 shift stages of {vld, err, dat} followed
//   by a hold-last output register, so the output changes exactly DLY clock
//   edges after in_vld and otherwise keeps its previous value.
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     in_vld/dat/err    response entering on the transfer cycle
//     out_dat/out_err   held response
// ---------------------------------------------------------------------------
module r5p_tcb_mem_sub_pipe #(
  parameter int DLY = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         in_err,
  output logic [W-1:0] out_dat,
  output logic         out_err
);

  logic       lst_vld;
  logic [W:0] lst_dat;
  logic [W:0] out_q;

  generate
    if (DLY <= 1) begin : g_direct
      assign lst_vld = in_vld;
      assign lst_dat = {in_err, in_dat};
    end else begin : g_shift
      logic [DLY-2:0] vld_q;
      logic [W:0]     dat_q [DLY-1];

      // Only the valid bits need reset; stale data is never selected.
      always_ff @(posedge clk) begin
        if (!rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= in_vld;
          for (int i = 1; i < DLY-1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_q[0] <= {in_err, in_dat};
        for (int i = 1; i < DLY-1; i++) dat_q[i] <= dat_q[i-1];
      end

      assign lst_vld = vld_q[DLY-2];
      assign lst_dat = dat_q[DLY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)         out_q <= '0;
    else if (lst_vld) out_q <= lst_dat;
  end

  assign {out_err, out_dat} = out_q;

endmodule

// File: rtl/r5p_tcb_mem_sub.sv
// ---------------------------------------------------------------------------
// r5p_tcb_mem_sub
//   Single-port TCB-Lite subordinate memory (IFU instruction / LSU data).
//   One request per cycle, writes commit on the transfer edge, read data
//   appears DLY cycles after the transfer and is held until the next read.
//   Parameters: XLEN (32 only), SIZ (bytes, power of two), DLY (1..4),
//               INI (preload file name, reserved for the integrating
//               environment; contents otherwise start undefined).
//   Ports:
//     clk  clock
//     rst  synchronous active-low reset (array contents are kept)
//     bpr  back-pressure; 1 forces tcb.rdy low from the next cycle
//     tcb  TCB-Lite subordinate modport
//   Optional feature: define R5P_TCB_MEM_ERR_EN to flag misaligned, siz=3,
//   out-of-range and big-endian (ndn) accesses with rsp.sts.err; erroneous
//   writes are dropped and erroneous reads return zero. Without it, sts is
//   0, misaligned accesses use the decoded lanes and addresses wrap.
// ---------------------------------------------------------------------------
module r5p_tcb_mem_sub
  import r5p_tcb_mem_sub_pkg::*;
#(
  parameter int    XLEN = 32,
  parameter int    SIZ  = 2**14,
  parameter int    DLY  = 1,
  parameter string INI  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bpr,
  r5p_tcb_mem_sub_if.sub    tcb
);

  localparam int AW    = $clog2(SIZ);
  localparam int WORDS = SIZ / 4;

  logic                  rdy_q;
  logic                  trn;
  logic [AW-3:0]         idx;
  logic [3:0]            ben;
  logic                  err;
  logic [TCB_XLEN-1:0]   rd_word;
  logic [TCB_XLEN-1:0]   rsp_rdt;
  logic                  rsp_err;
  logic [TCB_XLEN-1:0]   mem [WORDS];

  // Registered ready: reset and back-pressure take effect one edge later.
  always_ff @(posedge clk) begin
    rdy_q <= rst & ~bpr;
  end

  assign tcb.rdy = rdy_q;
  assign trn     = tcb.vld & rdy_q;
  assign idx     = tcb.req.adr[AW-1:2];
  assign ben     = tcb_ben(tcb.req.siz, tcb.req.adr[1:0]);

`ifdef R5P_TCB_MEM_ERR_EN
  logic mis;
  logic unused;
  assign mis = ((tcb.req.siz == 2'd1) &  tcb.req.adr[0])
             | ((tcb.req.siz == 2'd2) & |tcb.req.adr[1:0]);
  assign err = mis
             | (tcb.req.siz == 2'd3)
             | (|tcb.req.adr[TCB_XLEN-1:AW])
             | tcb.req.ndn;
  assign unused = ^{tcb.req.lck, tcb.req.byt};
`else
  logic unused;
  assign err    = 1'b0;
  assign unused = ^{tcb.req.lck, tcb.req.ndn, tcb.req.byt, tcb.req.adr[TCB_XLEN-1:AW]};
`endif

  // A transfer that coincides with a reset edge must not commit.
  always_ff @(posedge clk) begin
    if (rst & trn & tcb.req.wen & ~err) begin
      for (int i = 0; i < 4; i++) begin
        if (ben[i]) mem[idx][8*i +: 8] <= tcb.req.wdt[8*i +: 8];
      end
    end
  end

  // Sampled before the write edge, so wen & ren returns the old word while a
  // read one cycle later sees the new one.
  assign rd_word = mem[idx];

  r5p_tcb_mem_sub_pipe #(
    .DLY (DLY),
    .W   (TCB_XLEN)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (trn & (tcb.req.ren | err)),
    .in_dat  (err ? '0 : rd_word),
    .in_err  (err),
    .out_dat (rsp_rdt),
    .out_err (rsp_err)
  );

  assign tcb.rsp = '{rdt: rsp_rdt, sts: '{err: rsp_err}};

endmodule

// File: tb/tb_r5p_tcb_mem_sub.sv
// ---------------------------------------------------------------------------
// tb_r5p_tcb_mem_sub
//   Directed steps followed by random traffic. A byte-array memory and a
//   queue of timed responses predict rdy, rsp.rdt and rsp.sts.err on every
//   cycle; directed steps add spot checks against fixed constants.
// ---------------------------------------------------------------------------
module tb_r5p_tcb_mem_sub;
  import r5p_tcb_mem_sub_pkg::*;

  localparam int SIZ = 16384;
  localparam int DLY = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic bpr;
  always #5 clk = ~clk;

  r5p_tcb_mem_sub_if tcb_if ();

  r5p_tcb_mem_sub #(
    .XLEN (32),
    .SIZ  (SIZ),
    .DLY  (DLY),
    .INI  ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bpr (bpr),
    .tcb (tcb_if)
  );

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [SIZ];
  logic [31:0] exp_q [$];
  logic        exp_err_q [$];
  int          exp_due_q [$];
  int          cyc   = 0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_rdt = '0;
  logic        m_err = 1'b0;
  logic        m_ok  = 1'b0;
  logic        m_trn = 1'b0;
  logic        g_ndn = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic lane_on(input int l, input logic [1:0] s, input logic [1:0] a);
    if (s == 2'd0) return (l == int'(a));
    if (s == 2'd1) return ((l / 2) == int'(a[1]));
    return 1'b1;
  endfunction

  // One clock edge of the model, given what the bench drove in that cycle.
  task automatic model_edge(input logic v, input logic w, input logic r, input logic [31:0] a,
                            input logic [1:0] s, input logic [31:0] d, input logic nd,
                            input logic b, input logic rs);
    logic        e;
    int          wa;
    logic [31:0] old;
    cyc++;
    m_trn = 1'b0;
    if (!rs) begin
      exp_q.delete(); exp_err_q.delete(); exp_due_q.delete();
      m_rdt = '0; m_err = 1'b0; m_rdy = 1'b0; m_ok = 1'b1;
      return;
    end
    if (v && m_rdy) begin
      m_trn = 1'b1;
      e = 1'b0;
`ifdef R5P_TCB_MEM_ERR_EN
      e = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (s == 2'd3) ||
          (a >= 32'(SIZ)) || nd;
`else
      if (nd) e = 1'b0;
`endif
      wa  = int'(a % 32'(SIZ)) & ~3;
      old = {ref_mem[wa+3], ref_mem[wa+2], ref_mem[wa+1], ref_mem[wa]};
      if (r || e) begin
        exp_q.push_back(e ? 32'h0 : old);
        exp_err_q.push_back(e);
        exp_due_q.push_back(cyc + DLY - 1);
      end
      if (w && !e) begin
        for (int l = 0; l < 4; l++)
          if (lane_on(l, s, a[1:0])) ref_mem[wa+l] = d[8*l +: 8];
      end
    end
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      m_rdt = exp_q.pop_front();
      m_err = exp_err_q.pop_front();
      void'(exp_due_q.pop_front());
    end
    m_rdy = ~b;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic w, input logic r, input logic [31:0] a,
                      input logic [1:0] s, input logic [31:0] d, input logic b, input logic rs);
    tcb_if.vld     = v;
    tcb_if.req.wen = w;
    tcb_if.req.ren = r;
    tcb_if.req.adr = a;
    tcb_if.req.siz = s;
    tcb_if.req.wdt = d;
    tcb_if.req.ndn = g_ndn;
    tcb_if.req.lck = 1'($urandom_range(0, 1));
    tcb_if.req.byt = 4'($urandom_range(0, 15));
    bpr = b;
    rst = rs;
    @(posedge clk);
    model_edge(v, w, r, a, s, d, g_ndn, b, rs);
    @(negedge clk);
    if (m_ok) begin
      chk("rdy", {31'b0, tcb_if.rdy}, {31'b0, m_rdy});
      chk("rdt", tcb_if.rsp.rdt, m_rdt);
      chk("err", {31'b0, tcb_if.rsp.sts.err}, {31'b0, m_err});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  // Holds the request until the model sees it accepted, with a cycle budget.
  task automatic send(input logic w, input logic r, input logic [31:0] a,
                      input logic [1:0] s, input logic [31:0] d);
    int k;
    for (k = 0; k < 16; k++) begin
      step(1'b1, w, r, a, s, d, 1'b0, 1'b1);
      if (m_trn) break;
    end
    if (k == 16) chk("send_timeout", 32'(k), 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    tcb_if.vld = 1'b0;
    tcb_if.req = '0;
    bpr = 1'b0;
    rst = 1'b0;

    // Reset held with a write presented: rdy and rsp stay low.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h100, 2'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("t1_rdy_rst", {31'b0, tcb_if.rdy}, 32'h0);
      chk("t1_rdt_rst", tcb_if.rsp.rdt, 32'h0);
    end
    idle(1);
    chk("t1_rdy_rel", {31'b0, tcb_if.rdy}, 32'h1);

    // Fill the random-traffic window and the directed locations.
    for (int i = 0; i < 64; i++) send(1'b1, 1'b0, 32'h100 + 32'(4*i), 2'd2, $urandom);
    for (int i = 0; i < 4; i++)  send(1'b1, 1'b0, 32'(4*i), 2'd2, 32'hC0DE_0000 + 32'(4*i));

    // Word write then read in the next cycle.
    send(1'b1, 1'b0, 32'h10, 2'd2, 32'hDEAD_BEEF);
    send(1'b0, 1'b1, 32'h10, 2'd2, 32'h0);
    idle(DLY-1);
    chk("t2_word", tcb_if.rsp.rdt, 32'hDEAD_BEEF);

    // Byte and half-word merges on natural lanes.
    send(1'b1, 1'b0, 32'h20, 2'd2, 32'h1122_3344);
    send(1'b1, 1'b0, 32'h21, 2'd0, 32'h0000_AA00);
    send(1'b1, 1'b0, 32'h22, 2'd1, 32'hBBBB_0000);
    send(1'b0, 1'b1, 32'h20, 2'd2, 32'h0);
    idle(DLY-1);
    chk("t3_merge", tcb_if.rsp.rdt, 32'hBBBB_AA44);

    // Pipelined reads with a back-pressure gap; a request during bpr waits.
    send(1'b0, 1'b1, 32'h0, 2'd2, 32'h0);
    send(1'b0, 1'b1, 32'h4, 2'd2, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8, 2'd2, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8, 2'd2, 32'h0, 1'b1, 1'b1);
    chk("t4_hold", tcb_if.rsp.rdt, 32'hC0DE_0004);
    chk("t4_bpr_rdy", {31'b0, tcb_if.rdy}, 32'h0);
    send(1'b0, 1'b1, 32'h8, 2'd2, 32'h0);
    send(1'b0, 1'b1, 32'hC, 2'd2, 32'h0);
    idle(DLY-1);
    chk("t4_last", tcb_if.rsp.rdt, 32'hC0DE_000C);

    // Simultaneous write and read returns the old word.
    send(1'b1, 1'b1, 32'h8, 2'd2, 32'h1234_5678);
    idle(DLY-1);
    chk("wr_rd_old", tcb_if.rsp.rdt, 32'hC0DE_0008);

`ifndef R5P_TCB_MEM_ERR_EN
    // Upper address bits are ignored.
    send(1'b1, 1'b0, 32'h4000, 2'd2, 32'h5A5A_5A5A);
    send(1'b0, 1'b1, 32'h0, 2'd2, 32'h0);
    idle(DLY-1);
    chk("t5_wrap", tcb_if.rsp.rdt, 32'h5A5A_5A5A);
`else
    // Misaligned word write is flagged and dropped.
    send(1'b1, 1'b0, 32'h13, 2'd2, 32'h0000_0000);
    idle(DLY-1);
    chk("t6_err", {31'b0, tcb_if.rsp.sts.err}, 32'h1);
    send(1'b0, 1'b1, 32'h10, 2'd2, 32'h0);
    idle(DLY-1);
    chk("t6_ok", {31'b0, tcb_if.rsp.sts.err}, 32'h0);
    chk("t6_kept", tcb_if.rsp.rdt, 32'hDEAD_BEEF);
`endif

    // Reset mid-operation: in-flight read dropped, write during reset lost.
    send(1'b1, 1'b0, 32'h104, 2'd2, 32'h600D_F00D);
    send(1'b0, 1'b1, 32'h104, 2'd2, 32'h0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 32'h104, 2'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("rst_mid_rdt", tcb_if.rsp.rdt, 32'h0);
    idle(1);
    send(1'b0, 1'b1, 32'h104, 2'd2, 32'h0);
    idle(DLY-1);
    chk("rst_no_write", tcb_if.rsp.rdt, 32'h600D_F00D);

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 3)) << 14);
`ifdef R5P_TCB_MEM_ERR_EN
      g_ndn = ($urandom_range(0, 7) == 0);
`endif
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 4) == 0), 1'b1);
    end
    g_ndn = 1'b0;
    idle(DLY + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
